// File: rtl/i2c_master_arbiter.sv
// Two-requester round-robin arbiter and command sequencer in front of one i2c_master.
// Latches the winner's command, issues the start pulse and routes byte handshakes to the owner.
module i2c_master_arbiter #(
  parameter logic [1:0]  CLK_DIV       = 2'b01,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [13:0] addr,
  input  logic [1:0]  rnw,
  input  logic [3:0]  size,
  input  logic [15:0] wdata,
  input  logic [1:0]  wvalid,
  output logic [1:0]  gnt,
  output logic [1:0]  dreq,
  output logic [1:0]  rvalid,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic [7:0]  rdata,
  output logic [1:0]  m_clkDiv,
  output logic        m_start,
  output logic [6:0]  m_addr,
  output logic        m_rnw,
  output logic [1:0]  m_size,
  output logic [7:0]  m_data_i,
  output logic        m_data_valid,
  input  logic        m_busy,
  input  logic        m_newData,
  input  logic        m_dataReq,
  input  logic [7:0]  m_data_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  localparam int CW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [6:0]    addr_q, addr_d;
  logic          rnw_q, rnw_d;
  logic [1:0]    size_q, size_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic          busy_q;
  logic          win;

  // On a tie the requester that did not own the bus last time wins.
  assign win = (req == 2'b11) ? ~last_q : req[1];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    rnw_d   = rnw_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    done_d  = 2'b00;
    err_d   = 2'b00;
    case (state_q)
      S_IDLE: begin
        if ((|req) && !m_busy) begin
          owner_d = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          addr_d  = win ? addr[13:7] : addr[6:0];
          rnw_d   = rnw[win];
          size_d  = win ? size[3:2] : size[1:0];
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (m_busy) begin
          state_d = S_ACTIVE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = gnt_q;
          gnt_d   = 2'b00;
          last_d  = owner_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACTIVE: begin
        // The transfer ends on the falling edge of busy; it cannot be aborted by the requester.
        if (busy_q && !m_busy) begin
          done_d  = gnt_q;
          gnt_d   = 2'b00;
          last_d  = owner_q;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= 7'd0;
      rnw_q   <= 1'b0;
      size_q  <= 2'b00;
      cnt_q   <= '0;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      rnw_q   <= rnw_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= m_busy;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_route
      assign dreq[gi]   = m_dataReq & gnt_q[gi];
      assign rvalid[gi] = m_newData & gnt_q[gi];
    end
  endgenerate

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign err          = err_q;
  assign rdata        = m_data_o;
  assign m_clkDiv     = CLK_DIV;
  assign m_start      = (state_q == S_START);
  assign m_addr       = addr_q;
  assign m_rnw        = rnw_q;
  assign m_size       = size_q;
  assign m_data_i     = gnt_q[1] ? wdata[15:8] : (gnt_q[0] ? wdata[7:0] : 8'h00);
  assign m_data_valid = (|gnt_q) & wvalid[owner_q] &
                        ((state_q == S_WAIT) || (state_q == S_ACTIVE));

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: directed transaction sequence with randomized data,
// checked against a round-robin reference model kept here.
module tb_i2c_master_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [13:0] addr;
  logic [1:0]  rnw;
  logic [3:0]  size;
  logic [15:0] wdata;
  logic [1:0]  wvalid;
  logic [1:0]  gnt, dreq, rvalid, done, err;
  logic [7:0]  rdata;
  logic [1:0]  m_clkDiv;
  logic        m_start;
  logic [6:0]  m_addr;
  logic        m_rnw;
  logic [1:0]  m_size;
  logic [7:0]  m_data_i;
  logic        m_data_valid;
  logic        m_busy, m_newData, m_dataReq;
  logic [7:0]  m_data_o;

  int checks   = 0;
  int failures = 0;
  int last_m   = 1;
  int txn_no   = 0;

  always #5 clk = ~clk;

  i2c_master_arbiter #(.CLK_DIV(2'b01), .START_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .rnw(rnw), .size(size),
    .wdata(wdata), .wvalid(wvalid), .gnt(gnt), .dreq(dreq), .rvalid(rvalid),
    .done(done), .err(err), .rdata(rdata), .m_clkDiv(m_clkDiv), .m_start(m_start),
    .m_addr(m_addr), .m_rnw(m_rnw), .m_size(m_size), .m_data_i(m_data_i),
    .m_data_valid(m_data_valid), .m_busy(m_busy), .m_newData(m_newData),
    .m_dataReq(m_dataReq), .m_data_o(m_data_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: lone requester wins; on a tie the one not served last wins.
  function automatic int pick(input logic [1:0] r);
    if (r == 2'b11) return 1 - last_m;
    return r[1] ? 1 : 0;
  endfunction

  // Randomize byte-level handshakes and check that only the owner sees them.
  task automatic route(input int w);
    logic [1:0] oh;
    oh        = (w == 1) ? 2'b10 : 2'b01;
    m_dataReq = 1'($urandom);
    m_newData = 1'($urandom);
    m_data_o  = 8'($urandom);
    wdata     = 16'($urandom);
    wvalid    = 2'($urandom);
    #1;
    chk("dreq", dreq, m_dataReq ? oh : 2'b00);
    chk("rvalid", rvalid, m_newData ? oh : 2'b00);
    chk("rdata", rdata, m_data_o);
    chk("m_data_i", m_data_i, (w == 1) ? wdata[15:8] : wdata[7:0]);
    chk("m_data_valid", m_data_valid, wvalid[w]);
  endtask

  task automatic do_txn(input logic [1:0] r, input int exp_n, input bit tmo,
                        input int dly, input int hold, input bit rst_mid);
    int n, w;
    logic [1:0] oh;
    logic [6:0] ea;
    logic       er;
    logic [1:0] es;
    w   = pick(r);
    oh  = (w == 1) ? 2'b10 : 2'b01;
    ea  = (w == 1) ? addr[13:7] : addr[6:0];
    er  = rnw[w];
    es  = (w == 1) ? size[3:2] : size[1:0];
    req = r;
    n   = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 2'b00 && n < 12);
    txn_no++;
    $display("txn %0d: req=%b owner=%0d addr=0x%0h rnw=%b size=%b tmo=%0d wait=%0d",
             txn_no, r, w, ea, er, es, tmo, n);
    chk("gnt", gnt, oh);
    if (gnt == 2'b00) return;
    if (exp_n != 0) chk("grant_spacing", n, exp_n);
    chk("m_start_hi", m_start, 1'b1);
    chk("m_addr", m_addr, ea);
    chk("m_rnw", m_rnw, er);
    chk("m_size", m_size, es);
    // Requester inputs change mid-transfer; latched command must not follow.
    addr = 14'($urandom);
    rnw  = 2'($urandom);
    size = 4'($urandom);
    req  = 2'($urandom);
    @(negedge clk);
    chk("m_start_lo", m_start, 1'b0);
    if (tmo) begin
      n = 1;
      while (err == 2'b00 && n < 40) begin
        route(w);
        @(negedge clk);
        n++;
      end
      chk("tmo_cycles", n - 1, TMO);
      chk("err", err, oh);
      chk("gnt_after_err", gnt, 2'b00);
      chk("done_on_err", done, 2'b00);
      last_m = w;
      return;
    end
    for (int i = 0; i < dly; i++) begin
      route(w);
      @(negedge clk);
    end
    m_busy = 1'b1;
    for (int i = 0; i < hold; i++) begin
      route(w);
      chk("gnt_hold", gnt, oh);
      chk("m_addr_hold", m_addr, ea);
      chk("m_size_hold", m_size, es);
      chk("done_early", done, 2'b00);
      if (rst_mid && i == hold / 2) begin
        rst    = 1'b0;
        m_busy = 1'b0;
        @(negedge clk);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_m_start", m_start, 1'b0);
        chk("rst_m_addr", m_addr, 7'd0);
        chk("rst_m_rnw", m_rnw, 1'b0);
        chk("rst_m_size", m_size, 2'b00);
        chk("rst_done", done, 2'b00);
        chk("rst_err", err, 2'b00);
        rst    = 1'b1;
        last_m = 1;
        return;
      end
      addr = 14'($urandom);
      req  = 2'($urandom);
      @(negedge clk);
    end
    m_busy    = 1'b0;
    m_dataReq = 1'b0;
    m_newData = 1'b0;
    @(negedge clk);
    chk("done", done, oh);
    chk("gnt_after_done", gnt, 2'b00);
    chk("err_on_done", err, 2'b00);
    chk("m_data_valid_idle", m_data_valid, 1'b0);
    chk("m_data_i_idle", m_data_i, 8'h00);
    last_m = w;
  endtask

  initial begin
    rst = 1'b0; req = 2'b00; addr = '0; rnw = '0; size = '0; wdata = '0; wvalid = '0;
    m_busy = 1'b0; m_newData = 1'b0; m_dataReq = 1'b0; m_data_o = '0;
    repeat (3) @(negedge clk);
    chk("reset_gnt", gnt, 2'b00);
    chk("reset_m_start", m_start, 1'b0);
    chk("reset_m_addr", m_addr, 7'd0);
    chk("reset_m_rnw", m_rnw, 1'b0);
    chk("reset_m_size", m_size, 2'b00);
    chk("reset_done", done, 2'b00);
    chk("reset_err", err, 2'b00);
    chk("m_clkDiv", m_clkDiv, 2'b01);
    rst = 1'b1;

    // Tie from reset: requester 0, then 1, then 0 again.
    addr = {7'h22, 7'h40}; rnw = 2'b10; size = 4'b1001;
    do_txn(2'b11, 0, 1'b0, 3, 50, 1'b0);
    do_txn(2'b11, 2, 1'b0, 2, 10, 1'b0);
    do_txn(2'b11, 2, 1'b0, 1, 10, 1'b0);
    // Lone requester may be served back to back.
    addr = {7'h11, 7'h40}; rnw = 2'b00; size = 4'b0001;
    do_txn(2'b01, 2, 1'b0, 3, 50, 1'b0);

    for (int k = 0; k < 8; k++) begin
      addr = 14'($urandom);
      rnw  = 2'($urandom);
      size = 4'($urandom);
      do_txn(2'($urandom_range(1, 3)), 2, 1'b0, $urandom_range(0, 4), $urandom_range(1, 20), 1'b0);
    end

    // Start timeout, then the other requester is served without a gap.
    do_txn(2'b11, 2, 1'b1, 0, 0, 1'b0);
    do_txn(2'b11, 1, 1'b0, 2, 8, 1'b0);

    // Master busy externally: no grant until it goes low.
    m_busy = 1'b1;
    req    = 2'b01;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("busy_block_gnt", gnt, 2'b00);
    end
    m_busy = 1'b0;
    do_txn(2'b01, 1, 1'b0, 1, 6, 1'b0);

    // Reset mid-transfer, then requester 0 wins a tie.
    do_txn(2'b10, 2, 1'b0, 2, 20, 1'b1);
    do_txn(2'b11, 0, 1'b0, 1, 5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
Two-requester round-robin arbiter and transaction sequencer placed in front of a single i2c_master instance. It grants the shared master to one requester at a time and latches that requester's command (address, direction, byte count). It issues the start pulse, routes the byte-level handshakes (dataReq/newData/data) to the owner only, and releases the master when the I2C transfer ends. It replaces direct wiring of board logic to the master when two clients share one bus.

Parameters:
CLK_DIV, 2'b01, value driven constantly on m_clkDiv (bus speed select of i2c_master)
START_TIMEOUT, 16, clk cycles to wait for m_busy to rise after m_start before aborting

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (rst=0 resets)
req  in  2  level request per requester; bit i = requester i
addr  in  14  {addr1, addr0}, 7-bit slave address per requester
rnw  in  2  per-requester read_nwrite
size  in  4  {size1, size0}, 2-bit byte count code per requester (master's data_byte_size encoding)
wdata  in  16  {wdata1, wdata0}, write byte per requester
wvalid  in  2  per-requester write data valid
gnt  out  2  one-hot grant; at most one bit set
dreq  out  2  m_dataReq routed to owner
rvalid  out  2  m_newData routed to owner
done  out  2  1-cycle pulse to owner at transfer end
err  out  2  1-cycle pulse to owner on start timeout
rdata  out  8  m_data_o, shared; qualify with rvalid
m_clkDiv  out  2  = CLK_DIV
m_start  out  1  start pulse to master
m_addr  out  7  latched owner address
m_rnw  out  1  latched owner direction
m_size  out  2  latched owner byte count
m_data_i  out  8  owner's wdata
m_data_valid  out  1  owner's wvalid, gated
m_busy  in  1  master busy
m_newData  in  1  master read byte ready
m_dataReq  in  1  master requests write byte
m_data_o  in  8  master read data

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, gnt=0, m_start=0, m_addr=0, m_rnw=0, m_size=0, done=err=0, last=1 (requester 0 wins first tie).
- States:
  - IDLE: if any req and !m_busy, pick winner. If only one requests, grant it; if both request, grant !last. Latch addr/rnw/size of winner, set gnt[w] -> START.
  - START: m_start=1 for exactly one cycle -> WAIT.
  - WAIT: count cycles. m_busy=1 -> ACTIVE. If START_TIMEOUT cycles elapse with m_busy=0: pulse err[w], clear gnt, last=w -> IDLE.
  - ACTIVE: on m_busy 1->0 (registered edge) pulse done[w], clear gnt, last=w -> GAP.
  - GAP: one idle cycle, no grant -> IDLE.
- Minimum IDLE->next grant spacing: one GAP cycle; back-to-back same requester allowed only if the other is not requesting.
- Routing (combinational, zero latency):
  - dreq[i] = m_dataReq & gnt[i]
  - rvalid[i] = m_newData & gnt[i]
  - m_data_i = wdata of owner, 0 if none
  - m_data_valid = wvalid[owner] & (state ∈ {WAIT, ACTIVE})
  - non-owners see 0 on dreq/rvalid
- m_addr/m_rnw/m_size hold latched values until the next grant; they are unaffected by requester input changes mid-transfer.
- req dropped by owner mid-transfer: ignored; the transfer runs to completion and done still pulses (I2C cannot be aborted).
- m_busy already high in IDLE (master owned externally or still finishing): no grant until low.
- Reset mid-transfer: all outputs return to reset values next edge; the master is assumed reset by the same rst.

Test Plan:
- Single req[0], addr0=0x40, rnw=0, size=01, bench master raises busy 3 cycles after start and holds 50 cycles -> gnt=01, m_start one cycle, m_addr=0x40, done[0] one pulse when busy falls, gnt=00.
- req=11 from reset -> requester 0 granted first; after done, requester 1 granted after one GAP cycle; if req0 is reasserted, it is served third (alternation).
- Owner 1 read of 2 bytes, m_newData pulses with m_data_o=0xA5 then 0x3C -> rvalid[1] pulses twice, rdata matches, rvalid[0] stays 0.
- Owner 0 write, m_dataReq pulses, wdata0=0x55, wvalid0=1 -> dreq[0] follows, m_data_i=0x55, m_data_valid=1; wvalid1 toggling has no effect.
- Master never asserts busy -> err pulses on owner exactly START_TIMEOUT=16 cycles after WAIT entry, gnt cleared, other requester granted next.
- rst=0 asserted mid-ACTIVE -> next edge gnt=0, m_start=0, m_addr=0; after release, requester 0 wins a tie.
